// File: rtl/idex_stage.sv
// rtl/idex_stage.sv - DLX ID/EX pipeline register with load-use interlock, branch flush and memory freeze
// Optional load-use bubble counter enabled by defining IDEX_BUBBLE_CNT_EN.
module idex_stage #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          mem_busy,
    input  logic [4:0]    ID_rs,
    input  logic [4:0]    ID_rt,
    input  logic          ID_uses_rt,
    input  logic [4:0]    ID_dest,
    input  logic [DW-1:0] ID_rData1,
    input  logic [DW-1:0] ID_rData2,
    input  logic [DW-1:0] ID_imm,
    input  logic [DW-1:0] ID_pc4,
    input  logic          ID_RegWrite,
    input  logic          ID_MemWrite,
    input  logic          ID_MemRead,
    input  logic          ID_MemToReg,
    input  logic          ID_ALUSrc,
    input  logic [3:0]    ID_ALUop,
    output logic [4:0]    IDEX_rs,
    output logic [4:0]    IDEX_rt,
    output logic [4:0]    IDEX_dest,
    output logic [DW-1:0] IDEX_rData1,
    output logic [DW-1:0] IDEX_rData2,
    output logic [DW-1:0] IDEX_imm,
    output logic [DW-1:0] IDEX_pc4,
    output logic          IDEX_RegWrite,
    output logic          IDEX_MemWrite,
    output logic          IDEX_MemRead,
    output logic          IDEX_MemToReg,
    output logic          IDEX_ALUSrc,
    output logic [3:0]    IDEX_ALUop,
    output logic          hazard_stall
`ifdef IDEX_BUBBLE_CNT_EN
    ,
    output logic [31:0]   bubble_count
`endif
);

    typedef struct packed {
        logic [4:0]    rs;
        logic [4:0]    rt;
        logic [4:0]    dest;
        logic [DW-1:0] rdata1;
        logic [DW-1:0] rdata2;
        logic [DW-1:0] imm;
        logic [DW-1:0] pc4;
        logic          reg_write;
        logic          mem_write;
        logic          mem_read;
        logic          mem_to_reg;
        logic          alu_src;
        logic [3:0]    alu_op;
    } idex_t;

    typedef enum logic {RUN, LU_BUBBLE} state_t;

    idex_t  pipe_q, pipe_d;
    state_t state_q;
    logic   load_use;
    logic   lu_bubble;

    // Loads into r0 never create a dependency since r0 reads as zero.
    assign load_use = pipe_q.mem_read && (pipe_q.dest != 5'd0) &&
                      ((pipe_q.dest == ID_rs) || (ID_uses_rt && (pipe_q.dest == ID_rt)));

    // A flush already squashes the consumer, and a frozen stage cannot take a bubble.
    assign lu_bubble    = load_use && !flush && !mem_busy;
    assign hazard_stall = lu_bubble;

    always_comb begin
        pipe_d = pipe_q;
        if (flush) begin
            pipe_d = '0;
        end else if (mem_busy) begin
            pipe_d = pipe_q;
        end else if (load_use) begin
            pipe_d = '0;
        end else begin
            pipe_d.rs         = ID_rs;
            pipe_d.rt         = ID_rt;
            pipe_d.dest       = ID_dest;
            pipe_d.rdata1     = ID_rData1;
            pipe_d.rdata2     = ID_rData2;
            pipe_d.imm        = ID_imm;
            pipe_d.pc4        = ID_pc4;
            pipe_d.reg_write  = ID_RegWrite;
            pipe_d.mem_write  = ID_MemWrite;
            pipe_d.mem_read   = ID_MemRead;
            pipe_d.mem_to_reg = ID_MemToReg;
            pipe_d.alu_src    = ID_ALUSrc;
            pipe_d.alu_op     = ID_ALUop;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_q <= '0;
        end else begin
            pipe_q <= pipe_d;
        end
    end

    // LU_BUBBLE marks the cycle the inserted bubble sits in EX.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
        end else begin
            case (state_q)
                RUN:       if (lu_bubble) state_q <= LU_BUBBLE;
                LU_BUBBLE: if (flush || !mem_busy) state_q <= RUN;
                default:   state_q <= RUN;
            endcase
        end
    end

`ifdef IDEX_BUBBLE_CNT_EN
    logic [31:0] bubble_cnt_q, bubble_cnt_d;

    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        if (lu_bubble && (bubble_cnt_q != 32'hFFFF_FFFF)) begin
            bubble_cnt_d = bubble_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bubble_cnt_q <= '0;
        end else begin
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign bubble_count = bubble_cnt_q;
`endif

    assign IDEX_rs       = pipe_q.rs;
    assign IDEX_rt       = pipe_q.rt;
    assign IDEX_dest     = pipe_q.dest;
    assign IDEX_rData1   = pipe_q.rdata1;
    assign IDEX_rData2   = pipe_q.rdata2;
    assign IDEX_imm      = pipe_q.imm;
    assign IDEX_pc4      = pipe_q.pc4;
    assign IDEX_RegWrite = pipe_q.reg_write;
    assign IDEX_MemWrite = pipe_q.mem_write;
    assign IDEX_MemRead  = pipe_q.mem_read;
    assign IDEX_MemToReg = pipe_q.mem_to_reg;
    assign IDEX_ALUSrc   = pipe_q.alu_src;
    assign IDEX_ALUop    = pipe_q.alu_op;

endmodule

// File: tb/tb_idex_stage.sv
// tb/tb_idex_stage.sv - scoreboard bench for idex_stage with directed vectors
module tb_idex_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush, mem_busy, ID_uses_rt;
    logic [4:0]  ID_rs, ID_rt, ID_dest;
    logic [31:0] ID_rData1, ID_rData2, ID_imm, ID_pc4;
    logic        ID_RegWrite, ID_MemWrite, ID_MemRead, ID_MemToReg, ID_ALUSrc;
    logic [3:0]  ID_ALUop;
    logic [4:0]  IDEX_rs, IDEX_rt, IDEX_dest;
    logic [31:0] IDEX_rData1, IDEX_rData2, IDEX_imm, IDEX_pc4;
    logic        IDEX_RegWrite, IDEX_MemWrite, IDEX_MemRead, IDEX_MemToReg, IDEX_ALUSrc;
    logic [3:0]  IDEX_ALUop;
    logic        hazard_stall;
`ifdef IDEX_BUBBLE_CNT_EN
    logic [31:0] bubble_count;
`endif

    idex_stage #(.DW(32)) dut (
        .clk(clk), .rst(rst), .flush(flush), .mem_busy(mem_busy),
        .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_uses_rt(ID_uses_rt), .ID_dest(ID_dest),
        .ID_rData1(ID_rData1), .ID_rData2(ID_rData2), .ID_imm(ID_imm), .ID_pc4(ID_pc4),
        .ID_RegWrite(ID_RegWrite), .ID_MemWrite(ID_MemWrite), .ID_MemRead(ID_MemRead),
        .ID_MemToReg(ID_MemToReg), .ID_ALUSrc(ID_ALUSrc), .ID_ALUop(ID_ALUop),
        .IDEX_rs(IDEX_rs), .IDEX_rt(IDEX_rt), .IDEX_dest(IDEX_dest),
        .IDEX_rData1(IDEX_rData1), .IDEX_rData2(IDEX_rData2), .IDEX_imm(IDEX_imm), .IDEX_pc4(IDEX_pc4),
        .IDEX_RegWrite(IDEX_RegWrite), .IDEX_MemWrite(IDEX_MemWrite), .IDEX_MemRead(IDEX_MemRead),
        .IDEX_MemToReg(IDEX_MemToReg), .IDEX_ALUSrc(IDEX_ALUSrc), .IDEX_ALUop(IDEX_ALUop),
        .hazard_stall(hazard_stall)
`ifdef IDEX_BUBBLE_CNT_EN
        , .bubble_count(bubble_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          r, fl, bz, u, rst_late, frc;
        logic [4:0]  rs, rt, dest;
        logic        mr, rw;
        logic [31:0] d1;
        logic        e_st;
        logic [4:0]  e_rs, e_rt, e_dest;
        logic        e_mr, e_rw;
        logic [31:0] e_d1, e_cnt;
    } step_t;

    typedef struct {
        logic        st;
        logic [4:0]  rs, rt, dest;
        logic        mr, rw;
        logic [31:0] d1, cnt;
    } exp_t;

    step_t steps[$];
    exp_t  expq[$];
    event  samp_ev;
    int    passed = 0;
    int    total  = 0;

    // Secondary data fields are tied to rData1 so one column pins down all of them.
    function automatic logic [31:0] f_d2(input logic [31:0] x);
        return (x == 32'd0) ? 32'd0 : ~x;
    endfunction
    function automatic logic [31:0] f_imm(input logic [31:0] x);
        return (x == 32'd0) ? 32'd0 : x + 32'h10;
    endfunction

    function automatic void add(input bit r, fl, bz, input logic [4:0] rs, rt, input bit u,
                                input logic [4:0] dest, input logic mr, rw, input logic [31:0] d1,
                                input logic est, input logic [4:0] ers, ert, edst,
                                input logic emr, erw, input logic [31:0] ed1, ecnt);
        step_t s;
        s.r = r; s.fl = fl; s.bz = bz; s.u = u; s.rst_late = 1'b0; s.frc = 1'b0;
        s.rs = rs; s.rt = rt; s.dest = dest; s.mr = mr; s.rw = rw; s.d1 = d1;
        s.e_st = est; s.e_rs = ers; s.e_rt = ert; s.e_dest = edst;
        s.e_mr = emr; s.e_rw = erw; s.e_d1 = ed1; s.e_cnt = ecnt;
        steps.push_back(s);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act === want) passed++;
        else $display("FAIL %s: got %0h, required %0h", name, act, want);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk or samp_ev);
            if (expq.size() > 0) begin
                e = expq.pop_front();
                chk("hazard_stall", 32'(hazard_stall), 32'(e.st));
                chk("IDEX_rs", 32'(IDEX_rs), 32'(e.rs));
                chk("IDEX_rt", 32'(IDEX_rt), 32'(e.rt));
                chk("IDEX_dest", 32'(IDEX_dest), 32'(e.dest));
                chk("IDEX_MemRead", 32'(IDEX_MemRead), 32'(e.mr));
                chk("IDEX_RegWrite", 32'(IDEX_RegWrite), 32'(e.rw));
                chk("IDEX_MemWrite", 32'(IDEX_MemWrite), 32'(e.rs[0] & ~e.mr));
                chk("IDEX_MemToReg", 32'(IDEX_MemToReg), 32'(e.mr));
                chk("IDEX_ALUSrc", 32'(IDEX_ALUSrc), 32'(e.mr | e.rw));
                chk("IDEX_ALUop", 32'(IDEX_ALUop), 32'(e.d1[11:8]));
                chk("IDEX_rData1", IDEX_rData1, e.d1);
                chk("IDEX_rData2", IDEX_rData2, f_d2(e.d1));
                chk("IDEX_imm", IDEX_imm, f_imm(e.d1));
                chk("IDEX_pc4", IDEX_pc4, e.d1 << 2);
`ifdef IDEX_BUBBLE_CNT_EN
                chk("bubble_count", bubble_count, e.cnt);
`endif
            end
        end
    end

    initial begin : driver
        exp_t e;
        flush = 0; mem_busy = 0; ID_uses_rt = 0; ID_rs = 0; ID_rt = 0; ID_dest = 0;
        ID_rData1 = 0; ID_rData2 = 0; ID_imm = 0; ID_pc4 = 0; ID_ALUop = 0;
        ID_RegWrite = 0; ID_MemWrite = 0; ID_MemRead = 0; ID_MemToReg = 0; ID_ALUSrc = 0;
        //   r fl bz rs  rt u  dst mr rw d1          st rs  rt  dst mr rw d1          cnt
        add(1, 0, 0, 0,  0, 0, 0,  0, 0, 32'h0,      0, 0,  0,  0,  0, 0, 32'h0,      0);
        add(0, 0, 0, 3,  4, 1, 5,  0, 1, 32'h1234,   0, 0,  0,  0,  0, 0, 32'h0,      0);
        add(0, 0, 0, 2,  7, 0, 7,  1, 1, 32'h100,    0, 3,  4,  5,  0, 1, 32'h1234,   0);
        add(0, 0, 0, 1,  7, 1, 8,  0, 1, 32'h200,    1, 2,  7,  7,  1, 1, 32'h100,    0);
        add(0, 0, 0, 1,  7, 1, 8,  0, 1, 32'h200,    0, 0,  0,  0,  0, 0, 32'h0,      1);
        add(0, 0, 0, 3,  9, 0, 9,  1, 1, 32'h300,    0, 1,  7,  8,  0, 1, 32'h200,    1);
        add(0, 0, 0, 4,  9, 0, 10, 0, 1, 32'h400,    0, 3,  9,  9,  1, 1, 32'h300,    1);
        add(0, 0, 0, 1,  0, 0, 0,  1, 1, 32'h500,    0, 4,  9,  10, 0, 1, 32'h400,    1);
        add(0, 0, 0, 0,  0, 1, 11, 0, 1, 32'h600,    0, 1,  0,  0,  1, 1, 32'h500,    1);
        add(0, 0, 0, 2,  12,0, 12, 1, 1, 32'h700,    0, 0,  0,  11, 0, 1, 32'h600,    1);
        add(0, 1, 0, 12, 3, 1, 13, 0, 1, 32'h800,    0, 2,  12, 12, 1, 1, 32'h700,    1);
        add(0, 0, 0, 5,  6, 1, 14, 0, 1, 32'h900,    0, 0,  0,  0,  0, 0, 32'h0,      1);
        add(0, 0, 0, 1,  15,0, 15, 1, 1, 32'hA00,    0, 5,  6,  14, 0, 1, 32'h900,    1);
        add(0, 0, 1, 15, 2, 1, 16, 0, 1, 32'hB00,    0, 1,  15, 15, 1, 1, 32'hA00,    1);
        add(0, 0, 1, 15, 2, 1, 16, 0, 1, 32'hB00,    0, 1,  15, 15, 1, 1, 32'hA00,    1);
        add(0, 0, 1, 15, 2, 1, 16, 0, 1, 32'hB00,    0, 1,  15, 15, 1, 1, 32'hA00,    1);
        add(0, 0, 0, 15, 2, 1, 16, 0, 1, 32'hB00,    1, 1,  15, 15, 1, 1, 32'hA00,    1);
        add(0, 0, 0, 15, 2, 1, 16, 0, 1, 32'hB00,    0, 0,  0,  0,  0, 0, 32'h0,      2);
        add(0, 0, 0, 3,  20,0, 20, 1, 1, 32'hC00,    0, 15, 2,  16, 0, 1, 32'hB00,    2);
        add(0, 0, 0, 20, 1, 1, 21, 0, 1, 32'hD00,    1, 3,  20, 20, 1, 1, 32'hC00,    2);
        steps[$].rst_late = 1'b1;
        add(0, 0, 0, 20, 1, 1, 21, 0, 1, 32'hD00,    0, 0,  0,  0,  0, 0, 32'h0,      0);
        add(0, 0, 0, 0,  0, 0, 0,  0, 0, 32'hE00,    0, 20, 1,  21, 0, 1, 32'hD00,    0);
        add(0, 0, 0, 2,  7, 0, 7,  1, 1, 32'h1000,   0, 0,  0,  0,  0, 0, 32'hE00,    32'hFFFF_FFFE);
        steps[$].frc = 1'b1;
        add(0, 0, 0, 7,  0, 1, 8,  0, 1, 32'hF00,    1, 2,  7,  7,  1, 1, 32'h1000,   32'hFFFF_FFFE);
        add(0, 0, 0, 7,  0, 1, 8,  0, 1, 32'hF00,    0, 0,  0,  0,  0, 0, 32'h0,      32'hFFFF_FFFF);
        add(0, 0, 0, 2,  7, 0, 7,  1, 1, 32'h1000,   0, 7,  0,  8,  0, 1, 32'hF00,    32'hFFFF_FFFF);
        add(0, 0, 0, 7,  0, 1, 8,  0, 1, 32'hF00,    1, 2,  7,  7,  1, 1, 32'h1000,   32'hFFFF_FFFF);
        add(0, 0, 0, 7,  0, 1, 8,  0, 1, 32'hF00,    0, 0,  0,  0,  0, 0, 32'h0,      32'hFFFF_FFFF);

        foreach (steps[i]) begin
            @(posedge clk);
            #1;
            rst = steps[i].r; flush = steps[i].fl; mem_busy = steps[i].bz;
            ID_rs = steps[i].rs; ID_rt = steps[i].rt; ID_uses_rt = steps[i].u; ID_dest = steps[i].dest;
            ID_MemRead = steps[i].mr; ID_RegWrite = steps[i].rw;
            ID_MemWrite = steps[i].rs[0] & ~steps[i].mr; ID_MemToReg = steps[i].mr;
            ID_ALUSrc = steps[i].mr | steps[i].rw; ID_ALUop = steps[i].d1[11:8];
            ID_rData1 = steps[i].d1; ID_rData2 = f_d2(steps[i].d1);
            ID_imm = f_imm(steps[i].d1); ID_pc4 = steps[i].d1 << 2;
`ifdef IDEX_BUBBLE_CNT_EN
            if (steps[i].frc) begin
                force dut.bubble_cnt_q = 32'hFFFF_FFFE;
                #1 release dut.bubble_cnt_q;
            end
`endif
            e.st = steps[i].e_st; e.rs = steps[i].e_rs; e.rt = steps[i].e_rt; e.dest = steps[i].e_dest;
            e.mr = steps[i].e_mr; e.rw = steps[i].e_rw; e.d1 = steps[i].e_d1; e.cnt = steps[i].e_cnt;
            expq.push_back(e);
            if (steps[i].rst_late) begin
                @(negedge clk);
                #2 rst = 1'b1;
                e = '{st: 1'b0, rs: 5'd0, rt: 5'd0, dest: 5'd0, mr: 1'b0, rw: 1'b0, d1: 32'd0, cnt: 32'd0};
                expq.push_back(e);
                #1 -> samp_ev;
            end
        end
        repeat (2) @(posedge clk);
        if (expq.size() != 0) begin
            total++;
            $display("FAIL scoreboard_drain: got %0d pending, required 0", expq.size());
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/idex_stage.md
# idex_stage

ID/EX pipeline register for the pipelined DLX core, with the load-use interlock. It captures decoded operands and control from ID and presents registered `IDEX_*` fields to EX and to the forwarding unit. It detects a load in EX whose destination is a source of the instruction in ID, then requests a one-cycle stall of PC/IF-ID and inserts a bubble. It also supports a branch flush and a global memory freeze.

## Interface
- `DW`, default 32: datapath width (operands, immediate, PC+4).
- `clk`, input, 1: rising-edge clock.
- `rst`, input, 1: reset, asynchronous, active-high.
- `flush`, input, 1: branch resolved taken; squash the instruction entering ID/EX.
- `mem_busy`, input, 1: memory not ready; freeze the whole stage.
- `ID_rs`, `ID_rt`, input, 5 each: source register numbers in ID.
- `ID_uses_rt`, input, 1: the ID instruction reads `rt` as a source (R-type, store, branch-compare).
- `ID_dest`, input, 5: destination register already selected in ID (`rd` or `rt`).
- `ID_rData1`, `ID_rData2`, `ID_imm`, `ID_pc4`, input, DW each: operand values, sign-extended immediate, PC+4.
- `ID_RegWrite`, `ID_MemWrite`, `ID_MemRead`, `ID_MemToReg`, `ID_ALUSrc`, input, 1 each: decoded control.
- `ID_ALUop`, input, 4: ALU operation.
- `IDEX_*`, output, matching widths: registered copies of every `ID_*` field above except `ID_uses_rt`.
- `hazard_stall`, output, 1: hold PC and IF/ID this cycle.
- `bubble_count`, output, 32: present only with `IDEX_BUBBLE_CNT_EN`.

## Operation
- Hazard condition H is `IDEX_MemRead & (IDEX_dest != 0) & ((IDEX_dest == ID_rs) | (ID_uses_rt & (IDEX_dest == ID_rt)))`.
- `hazard_stall = H & ~flush & ~mem_busy`. It is combinational from registered state and ID inputs.
- A bubble sets all control outputs (`RegWrite`, `MemWrite`, `MemRead`, `MemToReg`, `ALUSrc`), `ALUop`, `dest`, `rs` and `rt` to 0. Data fields are also cleared to 0.
- Update priority at each rising edge:
  1. `rst`
  2. `flush`: load a bubble.
  3. `mem_busy`: hold all `IDEX_*`.
  4. H: load a bubble.
  5. Otherwise: capture the `ID_*` inputs.
- Two-state FSM:
  - RUN to LU_BUBBLE on an edge where H is taken as a bubble (priority 4).
  - LU_BUBBLE to RUN on the next non-frozen edge.
  - While in LU_BUBBLE, H is necessarily 0, because the bubble has `MemRead=0`. Back-to-back stalls for one load are therefore impossible.
  - A new load in ID may create a fresh hazard later.
- One bubble suffices. The dependent instruction reaches EX when the load is in MEM/WB, and the forwarding unit then selects write-back data.
- Loads targeting r0 never stall.
- A flush while H is true means the bubble is inserted by the flush, and `hazard_stall` stays 0 so IF redirects freely.

## Timing
- Register latency: `ID_*` at edge N appears on `IDEX_*` after edge N.
- `hazard_stall` reflects the current cycle. It is asserted exactly one cycle per load-use pair.
- Reset (asynchronous, any time, including mid-stall):
  - all `IDEX_*` = 0;
  - FSM = RUN;
  - `hazard_stall` = 0 once the registers clear;
  - `bubble_count` = 0.
- `mem_busy` held for k cycles:
  - `IDEX_*` frozen for k edges;
  - `hazard_stall` forced to 0;
  - a pending hazard resumes the cycle `mem_busy` drops.

## Configuration
- `IDEX_BUBBLE_CNT_EN` defined:
  - adds `bubble_count`, a 32-bit counter incremented on every edge that loads a bubble from priority 4 (load-use);
  - flushes are not counted;
  - saturates at 0xFFFFFFFF;
  - holds while `mem_busy`.
- `IDEX_BUBBLE_CNT_EN` undefined: the port and counter are absent, and all other behaviour is identical.

## Test plan
- Plain capture:
  - Stimulus: `ID_rs=3`, `ID_dest=5`, `ID_RegWrite=1`, `ID_rData1=0x1234`.
  - Required: after one edge `IDEX_rs=3`, `IDEX_dest=5`, `IDEX_rData1=0x1234`, and `hazard_stall=0` throughout.
- Load-use on rt:
  - Stimulus: `LW r7` in EX; ID has `ID_rt=7` with `ID_uses_rt=1`.
  - Required: `hazard_stall=1` for one cycle; the next edge gives `IDEX_RegWrite=0` and `IDEX_MemRead=0`; the following edge captures the held instruction.
  - With `ID_uses_rt=0`: no stall.
- r0 and flush:
  - Stimulus A: `LW r0` followed by a consumer of r0. Required: no stall.
  - Stimulus B: a hazard present with `flush=1`. Required: `hazard_stall=0` and a bubble loaded.
  - With the macro defined, `bubble_count` stays unchanged in both cases.
- Freeze:
  - Stimulus: `mem_busy=1` for 3 cycles while a hazard exists.
  - Required: `IDEX_*` unchanged for 3 edges and `hazard_stall=0`; after `mem_busy` drops, `hazard_stall=1` for one cycle.
- Async reset mid-stall:
  - Stimulus: assert `rst` between edges while `hazard_stall=1`.
  - Required: `IDEX_*` = 0 immediately, `hazard_stall=0`, and `bubble_count=0`.
- Counter saturation (macro defined):
  - Stimulus: force `bubble_count` to 0xFFFFFFFE, then cause 2 load-use stalls.
  - Required: `bubble_count` reads 0xFFFFFFFF and stays there.
